out_byte_uart_logger: RTL and testbench
=======================================

Name: out_byte_uart_logger

Overview:
- Downstream stage for a user module's 8-bit io_out bus.
- Watches the byte every clock and queues each changed value in a small FIFO.
- Serialises queued bytes as 8N1 UART frames on a single pin, so module results can be read on a bench scope or a host terminal.
- Sits between the user module outputs and the board-level tx pin.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 4: queue entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state rising-edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  monitored byte (user module io_out).
- enable  input  1  capture enable.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high while a frame is in flight.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - tx=1, busy=0, fifo_level=0, overflow=0.
  - last_sample=8'h00.
  - UART state=IDLE, bit counters cleared.
  - FIFO contents discarded, including any frame in progress, which is aborted immediately.
- Change detect:
  - last_sample <= data_in on every edge, regardless of enable.
  - push = enable && (data_in != last_sample).
  - After reset, a nonzero data_in counts as a change.
- FIFO:
  - Synchronous, first-in first-out; read and write pointers wrap modulo FIFO_DEPTH.
  - A push is accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow <= 1. Overflow clears only on reset.
  - Simultaneous push and pop leaves fifo_level unchanged.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_level != 0: pop the head byte into the shift register, clear the bit timer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After 8 bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy = (state != IDLE).
- Latency: a change sampled at edge E0 is pushed at E0 (level becomes 1). The pop happens at E1 and tx falls after E1 (registered tx).
- Frame length is 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly one IDLE cycle, giving a period of 10*CLKS_PER_BIT+1.
- enable low does not stop transmission of bytes already queued.
- tx is driven from a register: glitch-free, with no combinational path from data_in.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: plain 8N1 as above. The PARITY state and its logic are not present.

Test Plan:
- Reset release, enable=1, data_in held at 0x00 for 50 cycles -> tx stays 1, busy=0, fifo_level=0, overflow=0.
- data_in 0x00->0xA5, CLKS_PER_BIT=4 -> tx falls 2 edges after the change. Bit sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1. busy high for 40 cycles, then low.
- data_in stepped 0x01..0x06 on six consecutive edges:
  - fifo_level peaks at 4.
  - The 0x06 push is dropped and overflow=1.
  - Frames 0x01..0x05 are transmitted in order; overflow stays 1 afterwards.
- enable=0 while data_in toggles 0x00/0xFF for 20 cycles -> no push, tx=1. Then enable=1 with data_in steady at 0xFF -> no frame, because last_sample already equals 0xFF.
- Reset pulse (reset=0 for 1 cycle) mid-DATA of a 0x3C frame with 2 bytes queued -> tx=1 immediately, fifo_level=0, busy=0. No further frames while data_in is stable.
- UART_PARITY_EN defined, send 0x07 -> parity bit 1, frame of 11 bits. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/out_byte_uart_logger.sv
// Captures each change on an 8-bit bus into a small FIFO and streams it out as UART frames.
// Define UART_PARITY_EN to append an even-parity bit (8E1 framing instead of 8N1).
module out_byte_uart_logger #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          enable,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [7:0]    last_sample_reg;
    logic          overflow_reg;
    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          busy_reg;
`ifdef UART_PARITY_EN
    logic          parity_reg;
`endif

    logic       push_req;
    logic       pop;
    logic       push_ok;
    logic       bit_done;
    logic [7:0] head;

    assign push_req = enable && (data_in != last_sample_reg);
    assign pop      = (state_reg == ST_IDLE) && (level_reg != '0);
    // A full queue still accepts a byte when the head leaves on the same edge.
    assign push_ok  = push_req && ((level_reg < LW'(FIFO_DEPTH)) || pop);
    assign bit_done = (timer_reg == TW'(CLKS_PER_BIT - 1));
    assign head     = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            last_sample_reg <= 8'h00;
            overflow_reg    <= 1'b0;
        end else begin
            last_sample_reg <= data_in;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg   <= head;
`ifdef UART_PARITY_EN
                        parity_reg  <= ^head;
`endif
                        timer_reg   <= '0;
                        bit_cnt_reg <= '0;
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= ST_DATA;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            // Next bit is presented straight from the pre-shift register.
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        tx_reg    <= 1'b1;
                        state_reg <= ST_STOP;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        timer_reg <= '0;
                        tx_reg    <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign fifo_level = level_reg;
    assign overflow   = overflow_reg;
endmodule

// File: tb/tb_out_byte_uart_logger.sv
// Randomised and directed bench for out_byte_uart_logger against a queue-based frame model.
// Define UART_PARITY_EN for both bench and design to check 8E1 framing.
module tb_out_byte_uart_logger;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       enable = 1'b1;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    out_byte_uart_logger #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enable     (enable),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending bytes, last sampled value, sticky overflow, and the position
    // (in clocks) inside the frame currently on the wire, -1 when the line is idle.
    logic [7:0] q[$];
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_byte = 8'h00;
    int         m_pos  = -1;
    bit         m_ovf  = 1'b0;

    function automatic logic exp_tx();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
`ifdef UART_PARITY_EN
        if (idx == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = 8'h00;
        m_pos  = -1;
        m_ovf  = 1'b0;
    endtask

    always @(posedge clk) begin : model
        int  lvl;
        bit  do_pop;
        bit  do_push;
        if (reset) begin
            lvl     = q.size();
            do_pop  = (m_pos < 0) && (lvl != 0);
            do_push = enable && (data_in != m_last);
            if (do_pop) begin
                m_byte = q.pop_front();
                m_pos  = 0;
            end else if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME_LEN) m_pos = -1;
            end
            if (do_push) begin
                if (lvl < DEPTH || do_pop) q.push_back(data_in);
                else m_ovf = 1'b1;
            end
            m_last = data_in;
        end
    end

    always @(negedge clk) begin
        check("tx", 32'(tx), 32'(exp_tx()));
        check("busy", 32'(busy), 32'(m_pos >= 0));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    end

    // Asynchronous pulse placed between edges; outputs must clear before any clock.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        reset   = 1'b0;
        data_in = 8'h00;
        model_reset();
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        hold(3);
        reset = 1'b1;
        hold(50);
        $display("txn idle: 0x00 held, errors so far %0d", n_err);

        data_in = 8'hA5;
        hold(50);
        $display("txn frame: 0xA5, errors so far %0d", n_err);

        for (int v = 1; v <= 6; v++) begin
            data_in = 8'(v);
            @(negedge clk);
        end
        check("burst_ovf", 32'(overflow), 32'd1);
        hold(5 * (FRAME_LEN + 1) + 10);
        $display("txn burst: 0x01..0x06, errors so far %0d", n_err);

        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_in = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        data_in = 8'hFF;
        @(negedge clk);
        enable = 1'b1;
        hold(30);
        check("no_frame_busy", 32'(busy), 32'd0);
        $display("txn enable-off toggles, errors so far %0d", n_err);

        data_in = 8'h00;
        hold(FRAME_LEN + 5);
        data_in = 8'h3C;
        @(negedge clk);
        data_in = 8'h11;
        @(negedge clk);
        data_in = 8'h22;
        hold(8);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        reset_pulse();
        hold(FRAME_LEN + 10);
        $display("txn reset mid-frame, errors so far %0d", n_err);

        data_in = 8'h07;
        hold(FRAME_LEN + 5);
        data_in = 8'h03;
        hold(FRAME_LEN + 5);
        $display("txn bytes 0x07, 0x03, errors so far %0d", n_err);

        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 14) == 0) data_in = 8'($urandom);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else @(negedge clk);
        end
        hold(DEPTH * (FRAME_LEN + 1) + 20);
        $display("txn random run, errors so far %0d", n_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
